// File: rtl/user_pkg.sv
// User-domain address map and shared types for the OBI demultiplexer.
//  - NumUserDomainSubordinates : number of mapped user subordinates
//  - User*AddrOffset / Range   : base and size of each user peripheral window
//  - user_demux_outputs_e      : demux output index names (error sbr last)
//  - user_addr_map             : rule table; UserSbrStart / UserSbrEnd are the
//                                packed start/end vectors derived from it
package user_pkg;

  localparam int unsigned NumUserDomainSubordinates = 2;

  localparam logic [31:0] UserRomAddrOffset = 32'h2000_0000;
  localparam logic [31:0] UserRomAddrRange  = 32'h0000_1000;
  localparam logic [31:0] UserCosAddrOffset = 32'h2000_1000;
  localparam logic [31:0] UserCosAddrRange  = 32'h0000_1000;

  // Data returned by the internal error subordinate.
  localparam logic [31:0] UserErrRdata = 32'hBADC_AB1E;

  typedef enum logic [1:0] {
    UserRom   = 2'd0,
    UserCos   = 2'd1,
    UserError = 2'd2
  } user_demux_outputs_e;

  typedef struct packed {
    user_demux_outputs_e idx;
    logic [31:0]         start_addr;
    logic [31:0]         end_addr;
  } addr_rule_t;

  localparam addr_rule_t user_addr_map [NumUserDomainSubordinates] = '{
    '{idx: UserRom, start_addr: UserRomAddrOffset,
      end_addr: UserRomAddrOffset + UserRomAddrRange},
    '{idx: UserCos, start_addr: UserCosAddrOffset,
      end_addr: UserCosAddrOffset + UserCosAddrRange}
  };

  typedef logic [NumUserDomainSubordinates-1:0][31:0] user_addr_vec_t;

  function automatic user_addr_vec_t user_rule_starts();
    user_addr_vec_t v;
    for (int i = 0; i < NumUserDomainSubordinates; i++) v[i] = user_addr_map[i].start_addr;
    return v;
  endfunction

  function automatic user_addr_vec_t user_rule_ends();
    user_addr_vec_t v;
    for (int i = 0; i < NumUserDomainSubordinates; i++) v[i] = user_addr_map[i].end_addr;
    return v;
  endfunction

  localparam user_addr_vec_t UserSbrStart = user_rule_starts();
  localparam user_addr_vec_t UserSbrEnd   = user_rule_ends();

endpackage

// File: rtl/user_obi_err_sbr.sv
// Internal error subordinate: grants every request and answers exactly one
// cycle later with err=1, a fixed rdata pattern and the captured request id.
//  clk_i, rst_ni          clock, asynchronous active-low reset
//  req_i / gnt_o          request / grant (gnt_o is constant 1)
//  aid_i                  request id, returned on rid_o
//  rvalid_o, rdata_o, err_o, rid_o   response
module user_obi_err_sbr
  import user_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   rid_o
);

  logic               rvalid_reg;
  logic [IdWidth-1:0] rid_reg;

  assign gnt_o = 1'b1;

  // Every accepted request produces a response on the following cycle, so
  // back-to-back requests yield back-to-back responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= 1'b0;
      rid_reg    <= '0;
    end else begin
      rvalid_reg <= req_i;
      if (req_i) rid_reg <= aid_i;
    end
  end

  assign rvalid_o = rvalid_reg;
  assign err_o    = rvalid_reg;
  assign rdata_o  = rvalid_reg ? DataWidth'(UserErrRdata) : '0;
  assign rid_o    = rvalid_reg ? rid_reg : '0;

endmodule

// File: rtl/user_obi_demux.sv
// OBI demultiplexer: one manager port fanned out to NumSbr subordinates by
// address rules, plus an internal error subordinate for unmapped addresses.
// Responses return in order: a target switch waits until the previous target
// has drained, and at most MaxTrans transactions are outstanding.
//  clk_i, rst_ni                      clock, asynchronous active-low reset
//  mgr_req_i/gnt_o, addr/we/be/wdata/aid   manager request channel
//  mgr_rvalid_o/rdata_o/err_o/rid_o   manager response channel
//  sbr_req_o/gnt_i, sbr_addr..aid_o   per-subordinate request (fields broadcast)
//  sbr_rvalid_i/rdata_i/err_i/rid_i   per-subordinate responses
//  err_valid_o, err_addr_o, err_clr_i sticky decode-error capture, built only
//                                     with USER_OBI_DEMUX_ERR_CAPTURE_EN
module user_obi_demux
  import user_pkg::*;
#(
  parameter int unsigned NumSbr    = NumUserDomainSubordinates,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrStart = UserSbrStart,
  parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrEnd   = UserSbrEnd
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                mgr_req_i,
  output logic                                mgr_gnt_o,
  input  logic [AddrWidth-1:0]                mgr_addr_i,
  input  logic                                mgr_we_i,
  input  logic [DataWidth/8-1:0]              mgr_be_i,
  input  logic [DataWidth-1:0]                mgr_wdata_i,
  input  logic [IdWidth-1:0]                  mgr_aid_i,
  output logic                                mgr_rvalid_o,
  output logic [DataWidth-1:0]                mgr_rdata_o,
  output logic                                mgr_err_o,
  output logic [IdWidth-1:0]                  mgr_rid_o,
  output logic [NumSbr-1:0]                   sbr_req_o,
  input  logic [NumSbr-1:0]                   sbr_gnt_i,
  output logic [NumSbr-1:0][AddrWidth-1:0]    sbr_addr_o,
  output logic [NumSbr-1:0]                   sbr_we_o,
  output logic [NumSbr-1:0][DataWidth/8-1:0]  sbr_be_o,
  output logic [NumSbr-1:0][DataWidth-1:0]    sbr_wdata_o,
  output logic [NumSbr-1:0][IdWidth-1:0]      sbr_aid_o,
  input  logic [NumSbr-1:0]                   sbr_rvalid_i,
  input  logic [NumSbr-1:0][DataWidth-1:0]    sbr_rdata_i,
  input  logic [NumSbr-1:0]                   sbr_err_i,
  input  logic [NumSbr-1:0][IdWidth-1:0]      sbr_rid_i,
  output logic                                err_valid_o,
  output logic [AddrWidth-1:0]                err_addr_o,
  input  logic                                err_clr_i
);

  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
  localparam int unsigned SelWidth = $clog2(NumSbr + 1);
  localparam logic [SelWidth-1:0] ErrIdx = SelWidth'(NumSbr);

  logic [NumSbr-1:0]    match;
  logic [NumSbr-1:0]    last_sel_onehot;
  logic [SelWidth-1:0]  sel;
  logic [SelWidth-1:0]  last_sel_reg;
  logic [CntWidth-1:0]  cnt_reg;
  logic                 can_issue;
  logic                 sel_gnt;
  logic                 mgr_hs;
  logic                 rsp_valid;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;
  logic [IdWidth-1:0]   rsp_rid;

  logic                 err_req;
  logic                 err_gnt;
  logic                 err_rvalid;
  logic [DataWidth-1:0] err_rdata;
  logic                 err_err;
  logic [IdWidth-1:0]   err_rid;

  genvar gi;
  generate
    for (gi = 0; gi < NumSbr; gi++) begin : g_sbr
      assign match[gi]           = (mgr_addr_i >= SbrStart[gi]) && (mgr_addr_i < SbrEnd[gi]);
      assign last_sel_onehot[gi] = (last_sel_reg == SelWidth'(gi));
      assign sbr_req_o[gi]       = mgr_req_i & can_issue & (sel == SelWidth'(gi));
      assign sbr_addr_o[gi]      = mgr_addr_i;
      assign sbr_we_o[gi]        = mgr_we_i;
      assign sbr_be_o[gi]        = mgr_be_i;
      assign sbr_wdata_o[gi]     = mgr_wdata_i;
      assign sbr_aid_o[gi]       = mgr_aid_i;
    end
  endgenerate

  // Lowest matching rule wins; descending scan lets lower indices override.
  always_comb begin
    sel = ErrIdx;
    for (int i = NumSbr - 1; i >= 0; i--) begin
      if (match[i]) sel = SelWidth'(i);
    end
  end

  // Switching target is only safe once nothing is in flight, otherwise a
  // faster new target could overtake responses still owed by the old one.
  assign can_issue = (cnt_reg < CntWidth'(MaxTrans)) &&
                     ((cnt_reg == '0) || (sel == last_sel_reg));

  always_comb begin
    sel_gnt = (sel == ErrIdx) ? err_gnt : 1'b0;
    for (int i = 0; i < NumSbr; i++) begin
      if (sel == SelWidth'(i)) sel_gnt = sbr_gnt_i[i];
    end
  end

  assign err_req   = mgr_req_i & can_issue & (sel == ErrIdx);
  assign mgr_gnt_o = mgr_req_i & can_issue & sel_gnt;
  assign mgr_hs    = mgr_gnt_o;

  user_obi_err_sbr #(
    .DataWidth (DataWidth),
    .IdWidth   (IdWidth)
  ) u_err_sbr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (err_req),
    .aid_i    (mgr_aid_i),
    .gnt_o    (err_gnt),
    .rvalid_o (err_rvalid),
    .rdata_o  (err_rdata),
    .err_o    (err_err),
    .rid_o    (err_rid)
  );

  // Responses are taken only from the target of the most recent handshake.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    rsp_rid   = '0;
    if (last_sel_reg == ErrIdx) begin
      rsp_valid = err_rvalid;
      rsp_rdata = err_rdata;
      rsp_err   = err_err;
      rsp_rid   = err_rid;
    end
    for (int i = 0; i < NumSbr; i++) begin
      if (last_sel_reg == SelWidth'(i)) begin
        rsp_valid = sbr_rvalid_i[i];
        rsp_rdata = sbr_rdata_i[i];
        rsp_err   = sbr_err_i[i];
        rsp_rid   = sbr_rid_i[i];
      end
    end
  end

  // A response with nothing outstanding is stale and must not reach the manager.
  assign mgr_rvalid_o = rsp_valid && (cnt_reg != '0);
  assign mgr_rdata_o  = mgr_rvalid_o ? rsp_rdata : '0;
  assign mgr_err_o    = mgr_rvalid_o & rsp_err;
  assign mgr_rid_o    = mgr_rvalid_o ? rsp_rid : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      last_sel_reg <= '0;
    end else begin
      if (mgr_hs && !mgr_rvalid_o) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (!mgr_hs && mgr_rvalid_o) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (mgr_hs) last_sel_reg <= sel;
    end
  end

  // A subordinate answering while another owns the outstanding transactions
  // is a protocol violation; its response is dropped by the mux above.
  a_rvalid_from_selected : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_reg != '0) |-> ((sbr_rvalid_i & ~last_sel_onehot) == '0));

`ifdef USER_OBI_DEMUX_ERR_CAPTURE_EN
  logic                 err_valid_reg;
  logic [AddrWidth-1:0] err_addr_reg;
  logic                 err_hs;

  assign err_hs = mgr_hs && (sel == ErrIdx);

  // A new error arriving together with a clear is captured, not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_reg <= 1'b0;
      err_addr_reg  <= '0;
    end else if (err_hs && (!err_valid_reg || err_clr_i)) begin
      err_valid_reg <= 1'b1;
      err_addr_reg  <= mgr_addr_i;
    end else if (err_clr_i) begin
      err_valid_reg <= 1'b0;
    end
  end

  assign err_valid_o = err_valid_reg;
  assign err_addr_o  = err_addr_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_valid_o    = 1'b0;
  assign err_addr_o     = '0;
`endif

endmodule
